// File: rtl/i2c_slave_if.sv
// Bus-side and byte-side signals of the I2C target, bundled for one port.
// Combinational only: no storage, no latency.
// No backpressure: SCL is never stretched, byte consumers must keep up.
interface i2c_slave_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic [3:0] state;

  // Target side: samples the bus, drives SDA enable and byte strobes.
  modport slave (
    input  sclk, sda_in, tx_data,
    output sda_oe, tx_req, rx_data, rx_valid, rw, state
  );

  // Controller / environment side.
  modport master (
    output sclk, sda_in, tx_data,
    input  sda_oe, tx_req, rx_data, rx_valid, rw, state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with fixed 7-bit address: ACKs writes, serves reads MSB-first.
// Pin edges act 3 clk after they occur (2-flop sync + edge register).
// No backpressure: no clock stretching; tx_data must be ready when tx_req pulses.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input logic        clk,
  input logic        rst,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6
  } state_t;

  // [0],[1] synchronize, [2] holds the previous synchronized value.
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  // Second-half marker inside an ACK slot (ADDR_ACK/RX_ACK: ACK already
  // driven; TX_ACK: master ACK already sampled).
  logic       phase_q, phase_d;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic [7:0] byte_in;

  // Input pipeline shifts the raw pins one step per clk.
  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], bus.sclk};
    sda_pipe_d = {sda_pipe_q[1:0], bus.sda_in};
  end

  assign scl_s = scl_pipe_q[1];
  assign scl_p = scl_pipe_q[2];
  assign sda_s = sda_pipe_q[1];
  assign sda_p = sda_pipe_q[2];

  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign sda_rise = sda_s & ~sda_p;
  assign sda_fall = ~sda_s & sda_p;

  // SCL must be high in both the current and previous sample, so an SDA
  // edge coinciding with an SCL edge is treated as data, not START/STOP.
  assign start_det = scl_s & scl_p & sda_fall;
  assign stop_det  = scl_s & scl_p & sda_rise;

  assign byte_in = {shift_q[6:0], sda_s};

  // Next-state and output decode; STOP and START override every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    phase_d    = phase_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q[6:0] == ADDR) begin
                rw_d    = sda_s;
                phase_d = 1'b0;
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (rw_q) begin
                shift_d  = bus.tx_data;
                tx_req_d = 1'b1;
                sda_oe_d = ~bus.tx_data[7];
                cnt_d    = 3'd1;
                state_d  = S_TX;
              end else begin
                sda_oe_d = 1'b0;
                cnt_d    = 3'd0;
                state_d  = S_RX;
              end
            end
          end
        end

        S_RX: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = S_RX_ACK;
            end
          end
        end

        S_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_RX;
            end
          end
        end

        S_TX: begin
          // cnt_q = number of bits already driven; wraps to 0 after bit0.
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[~cnt_q];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end

        S_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_IDLE;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d  = 1'b0;
            shift_d  = bus.tx_data;
            tx_req_d = 1'b1;
            sda_oe_d = ~bus.tx_data[7];
            cnt_d    = 3'd1;
            state_d  = S_TX;
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      phase_q    <= phase_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rw       = rw_q;
  assign bus.state    = {1'b0, state_q};

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: write, reads, mismatch, repeated start, reset.
// SCL quarter period is 4 clk; all stimulus changes land between clk edges.
// Master side never stretches; bus SDA is the wired-AND of master and target.
module tb_i2c_slave;
  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic [7:0] tx_m;

  int checks = 0;
  int failures = 0;
  int txreq_cnt = 0;
  int rv_cnt = 0;
  int oe_cnt = 0;

  i2c_slave_if bus ();

  assign bus.sclk    = scl_m;
  assign bus.sda_in  = sda_m & ~bus.sda_oe;
  assign bus.tx_data = tx_m;

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse/drive monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.tx_req)   txreq_cnt <= txreq_cnt + 1;
    if (bus.rx_valid) rv_cnt    <= rv_cnt + 1;
    if (bus.sda_oe)   oe_cnt    <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    scl_m = 1'b0; sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  // One SCL period; obs is the bus SDA level mid-high.
  task automatic clock_bit(input logic b, output logic obs, output logic oe_mid);
    sda_m = b; #Q;
    scl_m = 1'b1; #Q;
    obs = bus.sda_in;
    oe_mid = bus.sda_oe;
    #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic o, e;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], o, e);
    clock_bit(1'b1, ack, e);
  endtask

  // Reads a byte; master answers ACK (nack=0) or NACK (nack=1).
  task automatic recv_byte(input logic nack, output logic [7:0] d, output logic oe9);
    logic o, e;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, o, e);
      d[i] = o;
    end
    clock_bit(nack, o, oe9);
  endtask

  initial begin
    logic       ack, oe9, o, e;
    logic [7:0] rd;
    int         base_tx, base_rv, base_oe;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_m = 8'h00;
    #20;
    check("reset_state",    8'(bus.state),    8'h00);
    check("reset_sda_oe",   8'(bus.sda_oe),   8'h00);
    check("reset_rx_data",  bus.rx_data,      8'h00);
    check("reset_rx_valid", 8'(bus.rx_valid), 8'h00);
    check("reset_tx_req",   8'(bus.tx_req),   8'h00);
    check("reset_rw",       8'(bus.rw),       8'h00);
    #10 rst = 1'b0;
    #Q;

    // Write A0 / 3C.
    base_rv = rv_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    check("wr_addr_ack", 8'(ack), 8'h00);
    send_byte(8'h3C, ack);
    check("wr_data_ack", 8'(ack), 8'h00);
    check("wr_rx_data", bus.rx_data, 8'h3C);
    check("wr_rx_valid_pulses", 8'(rv_cnt - base_rv), 8'h01);
    check("wr_rw", 8'(bus.rw), 8'h00);
    i2c_stop();
    #Q;
    check("wr_state_idle", 8'(bus.state), 8'h00);

    // Single read 96 with NACK.
    tx_m = 8'h96;
    base_tx = txreq_cnt;
    i2c_start();
    send_byte(8'hA1, ack);
    check("rd1_addr_ack", 8'(ack), 8'h00);
    check("rd1_rw", 8'(bus.rw), 8'h01);
    recv_byte(1'b1, rd, oe9);
    check("rd1_byte", rd, 8'h96);
    check("rd1_oe_9th", 8'(oe9), 8'h00);
    check("rd1_tx_req_pulses", 8'(txreq_cnt - base_tx), 8'h01);
    i2c_stop();
    #Q;
    check("rd1_state_idle", 8'(bus.state), 8'h00);

    // Two-byte read 5A (ACK) then C3 (NACK).
    tx_m = 8'h5A;
    base_tx = txreq_cnt;
    i2c_start();
    send_byte(8'hA1, ack);
    check("rd2_addr_ack", 8'(ack), 8'h00);
    tx_m = 8'hC3;
    recv_byte(1'b0, rd, oe9);
    check("rd2_byte0", rd, 8'h5A);
    check("rd2_state_tx", 8'(bus.state), 8'h05);
    recv_byte(1'b1, rd, oe9);
    check("rd2_byte1", rd, 8'hC3);
    check("rd2_oe_9th", 8'(oe9), 8'h00);
    check("rd2_tx_req_pulses", 8'(txreq_cnt - base_tx), 8'h02);
    i2c_stop();
    #Q;
    check("rd2_state_idle", 8'(bus.state), 8'h00);

    // Address mismatch: target stays off the bus.
    base_rv = rv_cnt;
    base_oe = oe_cnt;
    i2c_start();
    send_byte(8'hA2, ack);
    check("mm_addr_nack", 8'(ack), 8'h01);
    send_byte(8'h55, ack);
    check("mm_data_nack", 8'(ack), 8'h01);
    i2c_stop();
    #Q;
    check("mm_oe_cycles", 8'(oe_cnt - base_oe), 8'h00);
    check("mm_rx_valid_pulses", 8'(rv_cnt - base_rv), 8'h00);
    check("mm_state_idle", 8'(bus.state), 8'h00);

    // Repeated start: write 11, then read F0.
    i2c_start();
    send_byte(8'hA0, ack);
    check("rs_wr_addr_ack", 8'(ack), 8'h00);
    send_byte(8'h11, ack);
    check("rs_wr_data_ack", 8'(ack), 8'h00);
    check("rs_rx_data", bus.rx_data, 8'h11);
    tx_m = 8'hF0;
    i2c_start();
    check("rs_state_addr", 8'(bus.state), 8'h01);
    send_byte(8'hA1, ack);
    check("rs_rd_addr_ack", 8'(ack), 8'h00);
    recv_byte(1'b1, rd, oe9);
    check("rs_rd_byte", rd, 8'hF0);
    check("rs_rx_data_kept", bus.rx_data, 8'h11);
    i2c_stop();
    #Q;
    check("rs_state_idle", 8'(bus.state), 8'h00);

    // Reset while the target drives bit 3 low.
    tx_m = 8'h00;
    i2c_start();
    send_byte(8'hA1, ack);
    check("rst_addr_ack", 8'(ack), 8'h00);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, o, e);
    check("rst_pre_oe", 8'(bus.sda_oe), 8'h01);
    rst = 1'b1;
    #1;
    check("rst_async_oe", 8'(bus.sda_oe), 8'h00);
    #9;
    check("rst_state",    8'(bus.state),    8'h00);
    check("rst_rx_data",  bus.rx_data,      8'h00);
    check("rst_rx_valid", 8'(bus.rx_valid), 8'h00);
    check("rst_tx_req",   8'(bus.tx_req),   8'h00);
    check("rst_rw",       8'(bus.rw),       8'h00);
    sda_m = 1'b1; scl_m = 1'b1;
    #Q;
    rst = 1'b0;
    #Q;
    i2c_start();
    send_byte(8'hA0, ack);
    check("post_rst_addr_ack", 8'(ack), 8'h00);
    i2c_stop();
    #Q;
    check("post_rst_state_idle", 8'(bus.state), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
